// File: rtl/sha_madd_pipe_if.sv
// Operand/result handshake bundle for sha_madd_pipe.
// The master side is the environment; the adder itself connects through the slave modport.
interface sha_madd_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 5,
    parameter int CW      = $clog2(NUM_OPS)
);
    logic                     i_valid;
    logic                     o_ready;
    logic [NUM_OPS*WIDTH-1:0] i_ops;
    logic                     o_valid;
    logic                     i_ready;
    logic [WIDTH-1:0]         o_summ;
    logic [CW-1:0]            o_carry;

    modport master (
        output i_valid,
        output i_ops,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_summ,
        input  o_carry
    );

    modport slave (
        input  i_valid,
        input  i_ops,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_summ,
        output o_carry
    );
endinterface

// File: rtl/sha_madd_pipe.sv
// Pipelined multi-operand modular adder: carry-save reduction of NUM_OPS operands,
// a single carry-propagate add into the last register stage, global-stall valid/ready.
module sha_madd_pipe #(
    parameter int  WIDTH   = 32,
    parameter int  NUM_OPS = 5,
    parameter int  STAGES  = 2,
    localparam int CW      = $clog2(NUM_OPS)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_flush,
    sha_madd_pipe_if.slave bus
);

    // The exact sum of NUM_OPS unsigned WIDTH-bit values always fits in XW bits.
    localparam int XW = WIDTH + CW;

    logic              adv;
    logic              accept;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_shift;
    logic [XW-1:0]     res_q;
    logic [XW-1:0]     res_d;

    // Running carry-save pair after folding in operands 0..k+1.
    logic [XW-1:0] csa_s [NUM_OPS-1];
    logic [XW-1:0] csa_c [NUM_OPS-1];

    // Carry-save pair entering each register stage.
    logic [XW-1:0] in_s [STAGES];
    logic [XW-1:0] in_c [STAGES];

    assign adv         = !vld_q[STAGES-1] || bus.i_ready;
    assign bus.o_ready = adv && !i_flush;
    assign accept      = bus.i_valid && bus.o_ready;

    assign bus.o_valid = vld_q[STAGES-1];
    assign bus.o_summ  = res_q[WIDTH-1:0];
    assign bus.o_carry = res_q[XW-1:WIDTH];

    assign csa_s[0] = {{CW{1'b0}}, bus.i_ops[0 +: WIDTH]};
    assign csa_c[0] = {{CW{1'b0}}, bus.i_ops[WIDTH +: WIDTH]};

    // Each 3:2 compressor keeps s + c congruent to the partial sum modulo 2^XW,
    // so dropping the carry MSB on the shift loses nothing of the final result.
    for (genvar gi = 2; gi < NUM_OPS; gi++) begin : g_csa
        logic [XW-1:0] a;
        logic [XW-1:0] b;
        logic [XW-1:0] x;

        assign a = csa_s[gi-2];
        assign b = csa_c[gi-2];
        assign x = {{CW{1'b0}}, bus.i_ops[gi*WIDTH +: WIDTH]};

        assign csa_s[gi-1] = a ^ b ^ x;
        assign csa_c[gi-1] = ((a & b) | (a & x) | (b & x)) << 1;
    end

    assign in_s[0] = csa_s[NUM_OPS-2];
    assign in_c[0] = csa_c[NUM_OPS-2];

    // Carry-save slices between the compressor tree and the final adder.
    for (genvar gi = 0; gi < STAGES-1; gi++) begin : g_mid
        logic [XW-1:0] s_q;
        logic [XW-1:0] s_d;
        logic [XW-1:0] c_q;
        logic [XW-1:0] c_d;

        always_comb begin
            s_d = s_q;
            c_d = c_q;
            if (adv) begin
                s_d = in_s[gi];
                c_d = in_c[gi];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s_q <= '0;
                c_q <= '0;
            end else begin
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        assign in_s[gi+1] = s_q;
        assign in_c[gi+1] = c_q;
    end

    assign vld_shift[0] = accept;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_vld
        assign vld_shift[gi] = vld_q[gi-1];
    end

    // Flush only kills valid bits; stale data in the slices is harmless.
    always_comb begin
        res_d = res_q;
        vld_d = vld_q;
        if (adv) begin
            res_d = in_s[STAGES-1] + in_c[STAGES-1];
            vld_d = vld_shift;
        end
        if (i_flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            res_q <= '0;
        end else begin
            vld_q <= vld_d;
            res_q <= res_d;
        end
    end

endmodule
